instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, 8, queue capacity in 16-bit halfwords (power of two, >= 4).
REQ-002 SHALL have parameter PC_W, 25, halfword-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  discard queue contents and redirect fetch.
REQ-006 SHALL have port flush_pc_i  input  PC_W  new halfword address, sampled when flush_i=1.
REQ-007 SHALL have port mem_req_o  output  1  instruction-memory read request.
REQ-008 SHALL have port mem_addr_o  output  PC_W  request halfword address, bit0 always 0 (32-bit aligned).
REQ-009 SHALL have port mem_ack_i  input  1  read data valid; completes the request.
REQ-010 SHALL have port mem_rdata_i  input  32  [15:0] = halfword at mem_addr_o, [31:16] = mem_addr_o+1.
REQ-011 SHALL have port win_o  output  64  next 4 halfwords; [15:0] = oldest (at win_pc_o).
REQ-012 SHALL have port win_valid_o  output  3  count of valid halfwords in win_o, 0..4.
REQ-013 SHALL have port win_pc_o  output  PC_W  halfword address of win_o[15:0].
REQ-014 SHALL have port pop_i  input  3  halfwords consumed this cycle, 0..4.

Function
REQ-015 SHALL hold a ring buffer of DEPTH halfwords with rd/wr pointers wrapping modulo DEPTH and a count register 0..DEPTH.
REQ-016 SHALL drive win_o, win_valid_o, win_pc_o from registered state only (no combinational path from any input); invalid halfword lanes SHALL be 0.
REQ-017 SHALL set win_valid_o = min(count, 4).
REQ-018 SHALL treat pop_i > win_valid_o as pop of win_valid_o (clamp); popped halfwords advance rd pointer and win_pc_o by the popped amount, modulo 2^PC_W.
REQ-019 SHALL allow at most one outstanding request; mem_req_o and mem_addr_o SHALL remain stable from assertion until the cycle mem_ack_i=1; mem_req_o deasserts the cycle after ack unless a new request is issued.
REQ-020 SHALL issue a request only when (DEPTH - count) >= 2 after the same-cycle pop is applied.
REQ-021 On ack, SHALL write both halfwords (fetch address += 2), except the first ack after a flush to an odd flush_pc_i, which writes only [31:16].
REQ-022 SHALL apply ack-write and pop in the same cycle: count_next = count + written - popped.
REQ-023 On flush_i=1, SHALL set count=0, win_pc_o=flush_pc_i, fetch address={flush_pc_i[PC_W-1:1],0}; flush SHALL override pop and any same-cycle ack data.
REQ-024 If a request is outstanding at flush, SHALL keep mem_req_o/mem_addr_o unchanged until ack, discard that data, then issue the redirected request the cycle after the ack.
REQ-025 With no outstanding request, flush at cycle N SHALL yield mem_req_o=1 with the new address at N+1.
REQ-026 Ack at cycle M SHALL be visible on win_valid_o at M+1.
REQ-027 Full queue (count=DEPTH) SHALL suppress requests; empty queue (count=0) SHALL give win_valid_o=0, win_o=0.
REQ-028 States: IDLE (no request), REQ (waiting ack), REQ_DISCARD (waiting ack, data dropped); IDLE->REQ per REQ-020; REQ->IDLE/REQ on ack; REQ->REQ_DISCARD on flush; REQ_DISCARD->REQ on ack.

Reset
REQ-029 While rst_n=0: count=0, pointers=0, state IDLE, mem_req_o=0, mem_addr_o=0, win_valid_o=0, win_o=0, win_pc_o=0, odd-start flag=0.
REQ-030 First request (address 0) SHALL assert the first clk edge after rst_n rises; reset mid-request SHALL abandon it without waiting for ack.

Structure
REQ-031 PC_W, halfword width 16, window width 4, and the state enum SHALL live in shared package v850_pkg.
REQ-032 Storage SHALL be sub-module hw_ring_buf (2-halfword write port, 4-halfword read window); control stays in instr_prefetch_queue.

Verification
REQ-033 Reset release, mem acks every request next cycle with rdata={addr+1,addr} -> mem_addr_o 0,2,4,6; queue fills to 8, requests stop; win_o=0x0003_0002_0001_0000.
REQ-034 Full queue, pop_i=4 -> win_pc_o 0->4, win_valid_o stays 4, one new request at addr 8.
REQ-035 flush_i with flush_pc_i=0x15 while idle -> mem_addr_o=0x14 next cycle; after ack only halfword 0x15 queued, win_pc_o=0x15, win_valid_o=1.
REQ-036 flush during outstanding request, ack delayed 3 cycles -> addr held, ack data dropped, redirected request next cycle, win_valid_o=0 until its ack.
REQ-037 Simultaneous ack (2 halfwords) and pop_i=3 with count=5 -> count 4; pop_i=4 with win_valid_o=2 -> clamped, count 0.
REQ-038 rst_n low while mem_req_o=1 -> mem_req_o=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/v850_pkg.sv
// Shared V850 fetch-path constants and the prefetch control state encoding.
package v850_pkg;

    localparam int unsigned PC_W  = 25;
    localparam int unsigned HW_W  = 16;
    localparam int unsigned WIN_N = 4;
    localparam int unsigned WIN_W = WIN_N * HW_W;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REQ         = 2'd1,
        ST_REQ_DISCARD = 2'd2
    } pf_state_e;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory read bus: one request/ack pair carrying two halfwords.
interface instr_prefetch_queue_if #(
    parameter int unsigned PC_W = 25
);
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/hw_ring_buf.sv
// Halfword ring buffer: 0/1/2-halfword write per cycle, 4-halfword read window.
module hw_ring_buf
    import v850_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [1:0]        wr_cnt_i,
    input  logic [2*HW_W-1:0] wr_data_i,
    input  logic [2:0]        pop_i,
    output logic [CW-1:0]     count_o,
    output logic [WIN_W-1:0]  win_o,
    output logic [2:0]        win_valid_o
);

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            wr_ptr_q <= wr_ptr_q + AW'(wr_cnt_i);
            count_q  <= count_q + CW'(wr_cnt_i) - CW'(pop_i);
        end
    end

    // A single-halfword write is the odd-start case and carries the upper half.
    always_ff @(posedge clk) begin
        if (!clr_i) begin
            if (wr_cnt_i == 2'd1) begin
                mem_q[wr_ptr_q] <= wr_data_i[2*HW_W-1:HW_W];
            end else if (wr_cnt_i == 2'd2) begin
                mem_q[wr_ptr_q]               <= wr_data_i[HW_W-1:0];
                mem_q[AW'(wr_ptr_q + AW'(1))] <= wr_data_i[2*HW_W-1:HW_W];
            end
        end
    end

    always_comb begin
        win_o = '0;
        for (int i = 0; i < WIN_N; i++) begin
            if (CW'(i) < count_q) begin
                win_o[i*HW_W +: HW_W] = mem_q[AW'(rd_ptr_q + AW'(i))];
            end
        end
    end

    assign win_valid_o = (count_q >= CW'(WIN_N)) ? 3'(WIN_N) : 3'(count_q);
    assign count_o     = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches 32-bit pairs into a halfword ring and
// presents a 4-halfword decode window; handles flush/redirect mid-request.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = v850_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    output logic            mem_req_o,
    output logic [PC_W-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [31:0]     mem_rdata_i,
    output logic [63:0]     win_o,
    output logic [2:0]      win_valid_o,
    output logic [PC_W-1:0] win_pc_o,
    input  logic [2:0]      pop_i
);
    import v850_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pf_state_e       state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [PC_W-1:0] mem_addr_q, mem_addr_d;
    logic [PC_W-1:0] fetch_q, fetch_d;
    logic [PC_W-1:0] win_pc_q, win_pc_d;
    logic            odd_q, odd_d;

    logic [1:0]      wr_cnt;
    logic [2:0]      popped;
    logic [2:0]      ring_pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [2:0]      win_valid;

    assign popped   = (pop_i > win_valid) ? win_valid : pop_i;
    assign ring_pop = flush_i ? 3'd0 : popped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_q    <= '0;
            win_pc_q   <= '0;
            odd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_q    <= fetch_d;
            win_pc_q   <= win_pc_d;
            odd_q      <= odd_d;
        end
    end

    // fetch_q is the outstanding address in REQ, the redirect target in REQ_DISCARD.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_d    = fetch_q;
        win_pc_d   = win_pc_q + PC_W'(popped);
        odd_d      = odd_q;
        wr_cnt     = 2'd0;
        count_nxt  = count;

        case (state_q)
            ST_REQ: begin
                if (mem_ack_i && !flush_i) begin
                    wr_cnt  = odd_q ? 2'd1 : 2'd2;
                    odd_d   = 1'b0;
                    fetch_d = fetch_q + PC_W'(2);
                end
            end
            default: ;
        endcase

        if (flush_i) begin
            fetch_d   = {flush_pc_i[PC_W-1:1], 1'b0};
            win_pc_d  = flush_pc_i;
            odd_d     = flush_pc_i[0];
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(wr_cnt) - CW'(popped);
        end

        if (state_q == ST_IDLE || mem_ack_i) begin
            if (count_nxt <= CW'(DEPTH - 2)) begin
                state_d    = ST_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = fetch_d;
            end else begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        end else if (flush_i) begin
            state_d = ST_REQ_DISCARD;
        end
    end

    hw_ring_buf #(.DEPTH(DEPTH)) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (flush_i),
        .wr_cnt_i    (wr_cnt),
        .wr_data_i   (mem_rdata_i),
        .pop_i       (ring_pop),
        .count_o     (count),
        .win_o       (win_o),
        .win_valid_o (win_valid)
    );

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign win_pc_o    = win_pc_q;
    assign win_valid_o = win_valid;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: vector table plus hand sequences.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [24:0] flush_pc;
    logic [2:0]  pop;
    logic [63:0] win;
    logic [2:0]  win_valid;
    logic [24:0] win_pc;
    bit          auto_mem;
    int          n_vec  = 0;
    int          n_miss = 0;

    instr_prefetch_queue_if #(.PC_W(25)) bus ();

    instr_prefetch_queue #(.DEPTH(8), .PC_W(25)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .mem_req_o   (bus.mem_req),
        .mem_addr_o  (bus.mem_addr),
        .mem_ack_i   (bus.mem_ack),
        .mem_rdata_i (bus.mem_rdata),
        .win_o       (win),
        .win_valid_o (win_valid),
        .win_pc_o    (win_pc),
        .pop_i       (pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [24:0] fpc;
        logic [2:0]  pop;
        logic        e_req;
        logic [24:0] e_addr;
        logic [2:0]  e_vld;
        logic [24:0] e_pc;
        logic [63:0] e_win;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic f, logic [24:0] fp, logic [2:0] p, logic r,
                                logic [24:0] a, logic [2:0] v, logic [24:0] pc, logic [63:0] w);
        vec_t t;
        t.flush = f;  t.fpc = fp;   t.pop = p;
        t.e_req = r;  t.e_addr = a; t.e_vld = v; t.e_pc = pc; t.e_win = w;
        return t;
    endfunction

    // Zero-wait memory model: acks every cycle a request is visible, rdata={addr+1,addr}.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = {16'(bus.mem_addr + 25'd1), 16'(bus.mem_addr)};
        end
    endtask

    task automatic check(string nm, logic er, logic [24:0] ea, logic [2:0] ev,
                         logic [24:0] ep, logic [63:0] ew);
        n_vec++;
        if (bus.mem_req !== er) begin
            $display("FAIL %s mem_req got %0b want %0b", nm, bus.mem_req, er);
            n_miss++;
        end
        if (bus.mem_addr !== ea) begin
            $display("FAIL %s mem_addr got %h want %h", nm, bus.mem_addr, ea);
            n_miss++;
        end
        if (win_valid !== ev) begin
            $display("FAIL %s win_valid got %0d want %0d", nm, win_valid, ev);
            n_miss++;
        end
        if (win_pc !== ep) begin
            $display("FAIL %s win_pc got %h want %h", nm, win_pc, ep);
            n_miss++;
        end
        if (win !== ew) begin
            $display("FAIL %s win got %h want %h", nm, win, ew);
            n_miss++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        // fill from reset, pop full queue, odd flush, clamped pop
        tbl[0]  = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h00, 3'd0, 25'h00, 64'h0);
        tbl[1]  = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h02, 3'd2, 25'h00, 64'h0000_0000_0001_0000);
        tbl[2]  = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h04, 3'd4, 25'h00, 64'h0003_0002_0001_0000);
        tbl[3]  = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h06, 3'd4, 25'h00, 64'h0003_0002_0001_0000);
        tbl[4]  = mk(1'b0, 25'h0,  3'd0, 1'b0, 25'h06, 3'd4, 25'h00, 64'h0003_0002_0001_0000);
        tbl[5]  = mk(1'b0, 25'h0,  3'd0, 1'b0, 25'h06, 3'd4, 25'h00, 64'h0003_0002_0001_0000);
        tbl[6]  = mk(1'b0, 25'h0,  3'd4, 1'b1, 25'h08, 3'd4, 25'h04, 64'h0007_0006_0005_0004);
        tbl[7]  = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h0A, 3'd4, 25'h04, 64'h0007_0006_0005_0004);
        tbl[8]  = mk(1'b0, 25'h0,  3'd0, 1'b0, 25'h0A, 3'd4, 25'h04, 64'h0007_0006_0005_0004);
        tbl[9]  = mk(1'b1, 25'h15, 3'd3, 1'b1, 25'h14, 3'd0, 25'h15, 64'h0);
        tbl[10] = mk(1'b0, 25'h0,  3'd0, 1'b1, 25'h16, 3'd1, 25'h15, 64'h0000_0000_0000_0015);
        tbl[11] = mk(1'b0, 25'h0,  3'd1, 1'b1, 25'h18, 3'd2, 25'h16, 64'h0000_0000_0017_0016);
        tbl[12] = mk(1'b0, 25'h0,  3'd4, 1'b1, 25'h1A, 3'd2, 25'h18, 64'h0000_0000_0019_0018);

        rst_n = 1'b0; flush = 1'b0; flush_pc = '0; pop = '0;
        auto_mem = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 25'h0, 3'd0, 25'h0, 64'h0);
        rst_n = 1'b1;
        auto_mem = 1'b1;

        for (int i = 0; i < 13; i++) begin
            flush = tbl[i].flush; flush_pc = tbl[i].fpc; pop = tbl[i].pop;
            step();
            check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                  tbl[i].e_pc, tbl[i].e_win);
        end
        flush = 1'b0; pop = '0;

        // flush while a request is outstanding, ack 3 cycles late
        auto_mem = 1'b0; bus.mem_ack = 1'b0;
        flush = 1'b1; flush_pc = 25'h40;
        step(); flush = 1'b0;
        check("flush_busy", 1'b1, 25'h1A, 3'd0, 25'h40, 64'h0);
        step(); check("discard_hold1", 1'b1, 25'h1A, 3'd0, 25'h40, 64'h0);
        step(); check("discard_hold2", 1'b1, 25'h1A, 3'd0, 25'h40, 64'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        step(); bus.mem_ack = 1'b0;
        check("redirect", 1'b1, 25'h40, 3'd0, 25'h40, 64'h0);
        step(); check("redirect_wait", 1'b1, 25'h40, 3'd0, 25'h40, 64'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0041_0040;
        step(); bus.mem_ack = 1'b0;
        check("redirect_data", 1'b1, 25'h42, 3'd2, 25'h40, 64'h0000_0000_0041_0040);

        // build count=5 then simultaneous ack and pop, then clamped pop to empty
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0043_0042;
        step(); bus.mem_ack = 1'b0;
        check("fill4", 1'b1, 25'h44, 3'd4, 25'h40, 64'h0043_0042_0041_0040);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0045_0044;
        step(); bus.mem_ack = 1'b0;
        check("fill6", 1'b1, 25'h46, 3'd4, 25'h40, 64'h0043_0042_0041_0040);
        pop = 3'd1;
        step(); pop = '0;
        check("pop1_cnt5", 1'b1, 25'h46, 3'd4, 25'h41, 64'h0044_0043_0042_0041);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0047_0046; pop = 3'd3;
        step(); bus.mem_ack = 1'b0; pop = '0;
        check("ack_pop3", 1'b1, 25'h48, 3'd4, 25'h44, 64'h0047_0046_0045_0044);
        pop = 3'd2;
        step();
        check("pop2", 1'b1, 25'h48, 3'd2, 25'h46, 64'h0000_0000_0047_0046);
        pop = 3'd4;
        step(); pop = '0;
        check("pop_clamp", 1'b1, 25'h48, 3'd0, 25'h48, 64'h0);

        // asynchronous reset while a request is outstanding
        rst_n = 1'b0;
        #1;
        check("rst_async", 1'b0, 25'h0, 3'd0, 25'h0, 64'h0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_first_req", 1'b1, 25'h0, 3'd0, 25'h0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
